// File: rtl/acc_seq_ctrl.sv
// Enable sequencer for the per-column accumulator FIFO bank behind the systolic array.
// Optional protocol checker enabled by defining ACC_SEQ_CTRL_CHECK_EN.
module acc_seq_ctrl #(
  parameter int ARRAY_SIZE = 8,
  parameter int PASS_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [PASS_W-1:0]     i_num_passes,
  input  logic                  i_tile_start,
  input  logic [ARRAY_SIZE-1:0] i_full,
  input  logic [ARRAY_SIZE-1:0] i_empty,
  output logic [ARRAY_SIZE-1:0] o_rd_en,
  output logic [ARRAY_SIZE-1:0] o_wr_en,
  output logic [ARRAY_SIZE-1:0] o_ac_en,
  output logic [ARRAY_SIZE-1:0] o_out_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_tile_overrun,
  output logic [ARRAY_SIZE-1:0] o_proto_err
);

  localparam int CNT_W = $clog2(2 * ARRAY_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * ARRAY_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TILE = 3'd1,
    S_PASS      = 3'd2,
    S_DRAIN     = 3'd3,
    S_FIN       = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [PASS_W:0]     r_pass_idx, w_pass_nxt, w_pass_inc;
  logic [PASS_W-1:0]   r_k, w_k_nxt;
  logic                w_start_ok;
  logic                w_overrun_set;
  logic [ARRAY_SIZE-1:0] w_rd_nxt, w_wr_nxt, w_ac_nxt, w_ov_nxt, w_first_nxt;

  assign w_start_ok    = i_start && (r_state == S_IDLE);
  assign w_pass_inc    = r_pass_idx + (PASS_W + 1)'(1);
  assign w_overrun_set = i_tile_start &&
                         ((r_state == S_PASS) || (r_state == S_DRAIN) || (r_state == S_FIN));

  // Next-state and counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pass_nxt  = r_pass_idx;
    w_k_nxt     = r_k;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_WAIT_TILE;
          w_cnt_nxt   = '0;
          w_pass_nxt  = '0;
          w_k_nxt     = (i_num_passes == '0) ? PASS_W'(1) : i_num_passes;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_TILE: begin
        if (i_tile_start) begin
          w_state_nxt = S_PASS;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_WAIT_TILE;
        end
      end
      S_PASS: begin
        if (r_cnt == CNT_LAST) begin
          w_pass_nxt  = w_pass_inc;
          w_cnt_nxt   = '0;
          w_state_nxt = (w_pass_inc == {1'b0, r_k}) ? S_DRAIN : S_WAIT_TILE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_FIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Column c sees row r at cnt = c + r + 1; reads run one cycle ahead of writes
  always_comb begin
    int   n;
    logic in_rd;
    logic in_wr;
    w_rd_nxt    = '0;
    w_wr_nxt    = '0;
    w_ac_nxt    = '0;
    w_ov_nxt    = '0;
    w_first_nxt = '0;
    n           = int'(w_cnt_nxt);
    for (int c = 0; c < ARRAY_SIZE; c++) begin
      in_rd = (n >= c) && (n <= c + ARRAY_SIZE - 1);
      in_wr = (n >= c + 1) && (n <= c + ARRAY_SIZE);
      case (w_state_nxt)
        S_PASS: begin
          w_wr_nxt[c] = in_wr;
          if (w_pass_nxt != '0) begin
            w_rd_nxt[c]    = in_rd;
            w_ac_nxt[c]    = in_wr;
            w_first_nxt[c] = in_rd && (n == c);
          end else begin
            w_rd_nxt[c] = 1'b0;
          end
        end
        S_DRAIN: begin
          w_rd_nxt[c]    = in_rd;
          w_ov_nxt[c]    = in_wr;
          w_first_nxt[c] = in_rd && (n == c);
        end
        default: begin
          w_rd_nxt[c] = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_pass_idx     <= '0;
      r_k            <= '0;
      o_rd_en        <= '0;
      o_wr_en        <= '0;
      o_ac_en        <= '0;
      o_out_valid    <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_tile_overrun <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_pass_idx     <= w_pass_nxt;
      r_k            <= w_k_nxt;
      o_rd_en        <= w_rd_nxt;
      o_wr_en        <= w_wr_nxt;
      o_ac_en        <= w_ac_nxt;
      o_out_valid    <= w_ov_nxt;
      o_busy         <= (w_state_nxt == S_WAIT_TILE) || (w_state_nxt == S_PASS) ||
                        (w_state_nxt == S_DRAIN);
      o_done         <= (w_state_nxt == S_FIN);
      if (w_start_ok) begin
        o_tile_overrun <= 1'b0;
      end else if (w_overrun_set) begin
        o_tile_overrun <= 1'b1;
      end else begin
        o_tile_overrun <= o_tile_overrun;
      end
    end
  end

`ifdef ACC_SEQ_CTRL_CHECK_EN
  logic [ARRAY_SIZE-1:0] r_first_rd;
  logic [ARRAY_SIZE-1:0] r_proto_err;

  // The first read of a column is exempt: empty may still be settling for it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first_rd  <= '0;
      r_proto_err <= '0;
    end else begin
      r_first_rd <= w_first_nxt;
      if (w_start_ok) begin
        r_proto_err <= '0;
      end else begin
        r_proto_err <= r_proto_err | (o_wr_en & ~o_rd_en & i_full) |
                       (o_rd_en & ~r_first_rd & i_empty);
      end
    end
  end

  assign o_proto_err = r_proto_err;
`else
  logic w_unused;
  assign w_unused    = ^{i_full, i_empty, w_first_nxt};
  assign o_proto_err = '0;
`endif

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed self-checking bench for acc_seq_ctrl with a behavioural accumulator FIFO bank.
module tb_acc_seq_ctrl;
  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         tile_start;
  logic [7:0]   num_passes;
  logic [N-1:0] full, empty, force_full;
  logic [N-1:0] rd_en, wr_en, ac_en, out_valid, proto_err;
  logic         busy, done, tile_overrun;

  int checks = 0;
  int errors = 0;
  bit exp_ovr = 1'b0;

  logic [7:0] mem [N][16];
  logic [3:0] wp [N];
  logic [3:0] rp [N];
  logic [7:0] dout [N];

  acc_seq_ctrl #(.ARRAY_SIZE(N), .PASS_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_num_passes(num_passes),
    .i_tile_start(tile_start), .i_full(full), .i_empty(empty),
    .o_rd_en(rd_en), .o_wr_en(wr_en), .o_ac_en(ac_en), .o_out_valid(out_valid),
    .o_busy(busy), .o_done(done), .o_tile_overrun(tile_overrun), .o_proto_err(proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bank model: registered read port, array data is all ones, accumulate adds data_out
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        wp[c]   <= 4'd0;
        rp[c]   <= 4'd0;
        dout[c] <= 8'd0;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        if (rd_en[c]) begin
          dout[c] <= mem[c][rp[c]];
          rp[c]   <= rp[c] + 4'd1;
        end
        if (wr_en[c]) begin
          mem[c][wp[c]] <= ac_en[c] ? (dout[c] + 8'd1) : 8'd1;
          wp[c]         <= wp[c] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < N; c++) begin
      empty[c] = (wp[c] == rp[c]);
      full[c]  = force_full[c] || ((wp[c] - rp[c]) == 4'd8);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] mask(input int lo, input int hi, input int n);
    logic [N-1:0] m;
    for (int c = 0; c < N; c++) m[c] = (n >= c + lo) && (n <= c + hi);
    return m;
  endfunction

  task automatic do_start(input int k);
    num_passes = 8'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_ovr = 1'b0;
    checks++;
    if ({busy, done, tile_overrun, rd_en, wr_en, ac_en, out_valid, proto_err} !==
        {1'b1, 1'b0, 1'b0, 40'h0}) begin
      errors++;
      $display("FAIL start_accept: got busy=%b done=%b ovr=%b rd=%h wr=%h perr=%h, expected busy=1 others 0",
               busy, done, tile_overrun, rd_en, wr_en, proto_err);
    end
    tick();
  endtask

  task automatic run_pass(input bit acc, input int ovr_at, input int abort_at);
    logic [N-1:0] er, ew, ea;
    checks++;
    if ({busy, done, rd_en, wr_en, ac_en, out_valid} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL wait_tile: got busy=%b done=%b rd=%h wr=%h ac=%h ov=%h, expected busy=1 rest 0",
               busy, done, rd_en, wr_en, ac_en, out_valid);
    end
    tile_start = 1'b1;
    tick();
    tile_start = 1'b0;
    for (int n = 0; n < 2 * N; n++) begin
      ew = mask(1, N, n);
      er = acc ? mask(0, N - 1, n) : '0;
      ea = acc ? ew : '0;
      checks++;
      if ({rd_en, wr_en, ac_en, out_valid, busy, done, tile_overrun} !==
          {er, ew, ea, 8'h00, 1'b1, 1'b0, exp_ovr}) begin
        errors++;
        $display("FAIL pass acc=%0b cnt=%0d: got rd=%h wr=%h ac=%h ov=%h busy=%b done=%b ovr=%b, expected rd=%h wr=%h ac=%h ov=00 busy=1 done=0 ovr=%b",
                 acc, n, rd_en, wr_en, ac_en, out_valid, busy, done, tile_overrun, er, ew, ea, exp_ovr);
      end
      if (n == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_en, wr_en, ac_en, out_valid, busy, done, tile_overrun, proto_err} !== 43'h0) begin
          errors++;
          $display("FAIL async_reset: got rd=%h wr=%h ac=%h ov=%h busy=%b done=%b ovr=%b, expected all 0",
                   rd_en, wr_en, ac_en, out_valid, busy, done, tile_overrun);
        end
        exp_ovr = 1'b0;
        return;
      end
      tile_start = (n == ovr_at);
      tick();
      if (n == ovr_at) exp_ovr = 1'b1;
    end
    tile_start = 1'b0;
  endtask

  task automatic run_drain(input int val);
    logic [N-1:0] er, ev, bad;
    for (int n = 0; n < 2 * N; n++) begin
      er = mask(0, N - 1, n);
      ev = mask(1, N, n);
      bad = '0;
      for (int c = 0; c < N; c++) bad[c] = ev[c] && (dout[c] !== 8'(val));
      checks++;
      if ({rd_en, wr_en, ac_en, out_valid, busy, done, tile_overrun} !==
          {er, 8'h00, 8'h00, ev, 1'b1, 1'b0, exp_ovr}) begin
        errors++;
        $display("FAIL drain cnt=%0d: got rd=%h wr=%h ac=%h ov=%h busy=%b done=%b ovr=%b, expected rd=%h wr=00 ac=00 ov=%h busy=1 done=0 ovr=%b",
                 n, rd_en, wr_en, ac_en, out_valid, busy, done, tile_overrun, er, ev, exp_ovr);
      end
      checks++;
      if (bad !== '0) begin
        errors++;
        $display("FAIL drain_data cnt=%0d: columns %h do not hold %0d (col7=%0d col0=%0d)",
                 n, bad, val, dout[7], dout[0]);
      end
      tick();
    end
    checks++;
    if ({busy, done, rd_en, wr_en, ac_en, out_valid} !== {1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL fin: got busy=%b done=%b rd=%h wr=%h ov=%h, expected busy=0 done=1 rest 0",
               busy, done, rd_en, wr_en, out_valid);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL done_pulse: got busy=%b done=%b, expected 0 0", busy, done);
    end
    tick();
    checks++;
    if ({busy, done, tile_overrun} !== {2'b00, exp_ovr}) begin
      errors++;
      $display("FAIL fin_start_ignored: got busy=%b done=%b ovr=%b, expected 0 0 %b",
               busy, done, tile_overrun, exp_ovr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({rd_en, wr_en, ac_en, out_valid, busy, done, tile_overrun, proto_err} !== 43'h0) begin
      errors++;
      $display("FAIL reset_state: got rd=%h wr=%h busy=%b done=%b ovr=%b, expected all 0",
               rd_en, wr_en, busy, done, tile_overrun);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_pass();
    do_start(1);
    run_pass(1'b0, -1, -1);
    run_drain(1);
  endtask

  task automatic test_multi_pass();
    do_start(3);
    run_pass(1'b0, -1, -1);
    run_pass(1'b1, -1, -1);
    run_pass(1'b1, -1, -1);
    run_drain(3);
  endtask

  task automatic test_zero_passes();
    do_start(0);
    run_pass(1'b0, -1, -1);
    run_drain(1);
  endtask

  task automatic test_overrun();
    tile_start = 1'b1;
    tick();
    tile_start = 1'b0;
    tick();
    checks++;
    if ({busy, tile_overrun} !== 2'b00) begin
      errors++;
      $display("FAIL idle_tile_start: got busy=%b ovr=%b, expected 0 0", busy, tile_overrun);
    end
    do_start(1);
    run_pass(1'b0, 5, -1);
    run_drain(1);
    do_start(2);
    run_pass(1'b0, -1, -1);
    run_pass(1'b1, -1, -1);
    run_drain(2);
  endtask

  task automatic test_reset_mid_job();
    do_start(3);
    run_pass(1'b0, -1, -1);
    run_pass(1'b1, -1, 6);
    #10 rst_n = 1'b1;
    tick();
    checks++;
    if ({busy, done, rd_en, wr_en} !== 18'h0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%b done=%b rd=%h wr=%h, expected all 0",
               busy, done, rd_en, wr_en);
    end
    do_start(2);
    run_pass(1'b0, -1, -1);
    run_pass(1'b1, -1, -1);
    run_drain(2);
  endtask

  task automatic test_proto();
    do_start(1);
`ifdef ACC_SEQ_CTRL_CHECK_EN
    force_full = 8'h08;
    run_pass(1'b0, -1, -1);
    force_full = 8'h00;
    checks++;
    if (proto_err !== 8'h08) begin
      errors++;
      $display("FAIL proto_err_full: got %h, expected 08", proto_err);
    end
    run_drain(1);
    do_start(1);
    run_pass(1'b0, -1, -1);
    run_drain(1);
`else
    force_full = 8'h08;
    run_pass(1'b0, -1, -1);
    force_full = 8'h00;
    checks++;
    if (proto_err !== 8'h00) begin
      errors++;
      $display("FAIL proto_err_disabled: got %h, expected 00", proto_err);
    end
    run_drain(1);
`endif
  endtask

  initial begin
    start      = 1'b0;
    tile_start = 1'b0;
    num_passes = 8'd0;
    force_full = 8'h00;
    rst_n      = 1'b0;
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_zero_passes();
    test_overrun();
    test_reset_mid_job();
    test_proto();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_seq_ctrl.md
Name: acc_seq_ctrl

Overview:
- Sequencer for the per-column accumulator FIFO bank behind the systolic array.
- Generates per-column rd_en/wr_en/ac_en with the array's diagonal output skew. The first K-tile pass loads partial sums; later passes read-add-write them back; a final drain pass pops results out.
- Sits between the array/tile scheduler and the accumulator bank; it holds no datapath.

Parameters:
- ARRAY_SIZE, 8: number of columns/FIFOs and rows per tile (N).
- PASS_W, 8: width of the num_passes field.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a job; accepted only in IDLE
- num_passes  in  PASS_W  K-tiles to accumulate; latched on accepted start; 0 treated as 1
- tile_start  in  1  pulse one cycle before column 0 row 0 partial sum appears at the bank input
- full  in  N  per-column FIFO full flags
- empty  in  N  per-column FIFO empty flags
- rd_en  out  N  per-column FIFO read enable
- wr_en  out  N  per-column FIFO write enable
- ac_en  out  N  per-column accumulate select (write data = FIFO output + array data)
- out_valid  out  N  per-column: FIFO data_out holds a final result this cycle
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when drain completes
- tile_overrun  out  1  sticky; set by tile_start while a pass is active; cleared by start
- proto_err  out  N  sticky per column; exists only with the optional feature

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset asserted mid-job aborts immediately with the same values; FIFO contents are the bank's concern.
- States: IDLE, WAIT_TILE, PASS, DRAIN, FIN.
- IDLE -> WAIT_TILE on start:
  - latch K = max(num_passes, 1); pass_idx = 0; clear tile_overrun; busy = 1.
  - start in any other state is ignored.
- WAIT_TILE -> PASS on tile_start: cnt = 0 on the next cycle, then increments by 1 per cycle.
- PASS timing: column c row r data arrives at cnt = c + r + 1, for r in 0..N-1.
  - pass_idx == 0: wr_en[c] = 1 for cnt in [c+1, c+N]; ac_en = 0; rd_en = 0.
  - pass_idx > 0: rd_en[c] = 1 for cnt in [c, c+N-1], which prefetches the partial sum into data_out one cycle ahead.
  - pass_idx > 0: wr_en[c] = ac_en[c] = 1 for cnt in [c+1, c+N]. The overlap cycles give simultaneous rd+wr, which is legal in the bank.
- Pass end at cnt == 2N-1 (last write of column N-1):
  - pass_idx++.
  - If pass_idx == K, go to DRAIN with cnt = 0.
  - Otherwise go to WAIT_TILE.
- tile_start in PASS, DRAIN or FIN: ignored, sets tile_overrun. tile_start in IDLE: ignored, no flag.
- DRAIN:
  - rd_en[c] = 1 for cnt in [c, c+N-1].
  - out_valid[c] = 1 for cnt in [c+1, c+N], one cycle after each read because bank output is registered.
  - At cnt == 2N-1 go to FIN.
- FIN: done = 1 for one cycle, busy = 0, go to IDLE. A start in the same cycle is ignored.
- Counters:
  - cnt width is clog2(2N+1).
  - pass_idx width is PASS_W+1, so K = 2^PASS_W - 1 does not wrap.
- All enables are registered outputs, decoded from the next cnt/state; no combinational path from inputs to outputs.

Optional Feature:
- Macro ACC_SEQ_CTRL_CHECK_EN.
- Defined: proto_err[c] sets (sticky, cleared by start) whenever:
  - wr_en[c] && !rd_en[c] && full[c], or
  - rd_en[c] && empty[c] in pass_idx > 0 or DRAIN, excluding the very first rd cycle of a column when empty is expected low.
- Not defined: proto_err is tied to 0 and full/empty are unused.

Test Plan:
- N=8, num_passes=1, start, tile_start 2 cycles later -> wr_en[0] high cnt 1..8, wr_en[7] high cnt 8..15, ac_en stays 0; DRAIN out_valid[7] at cnt 8..15; done exactly 1 cycle; busy low after.
- num_passes=3, tiles of all-ones data -> rd_en[c] leads wr_en[c] by 1 cycle in passes 2 and 3; ac_en[c] == wr_en[c]; drained results are 3 in every slot.
- num_passes=0 -> behaves exactly as 1 pass.
- tile_start pulsed at cnt=5 of a pass -> tile_overrun=1, enable pattern unchanged; next start clears it.
- rst_n low at cnt=6 of pass 2 -> all outputs 0 asynchronously, IDLE; a later start runs a clean job.
- ACC_SEQ_CTRL_CHECK_EN: force full[3]=1 during pass 0 -> proto_err[3]=1, others 0; without the macro proto_err == 0.
